// File: rtl/retire_trace_if.sv
// ============================================================================
// Module      : retire_trace_if
// Description : Retirement capture and trace pop channels of the trace monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface retire_trace_if #(
    parameter int XLEN = 32
);
    logic            ret_valid;
    logic [XLEN-1:0] ret_pc;
    logic [31:0]     ret_inst;
    logic            ret_rd_we;
    logic [4:0]      ret_rd_addr;
    logic [XLEN-1:0] ret_rd_data;

    logic            pop;
    logic            pop_valid;
    logic [XLEN-1:0] pop_pc;
    logic [31:0]     pop_inst;
    logic            pop_rd_we;
    logic [4:0]      pop_rd_addr;
    logic [XLEN-1:0] pop_rd_data;

    modport master (
        output ret_valid, ret_pc, ret_inst, ret_rd_we, ret_rd_addr, ret_rd_data, pop,
        input  pop_valid, pop_pc, pop_inst, pop_rd_we, pop_rd_addr, pop_rd_data
    );

    modport slave (
        input  ret_valid, ret_pc, ret_inst, ret_rd_we, ret_rd_addr, ret_rd_data, pop,
        output pop_valid, pop_pc, pop_inst, pop_rd_we, pop_rd_addr, pop_rd_data
    );
endinterface

`default_nettype wire

// File: rtl/retire_trace_monitor.sv
// ============================================================================
// Module      : retire_trace_monitor
// Description : Cycle/retire counters, halt control and circular retirement trace.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module retire_trace_monitor #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 16,
    parameter int MAX_CYCLES = 8000,
    parameter int CNT_W      = 32
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    retire_trace_if.slave               trc,
    input  wire logic                   bp_en,
    input  wire logic [XLEN-1:0]        bp_pc,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow,
    output logic                        halt,
    output logic [1:0]                  halt_cause,
    output logic [CNT_W-1:0]            cycle_count,
    output logic [CNT_W-1:0]            retire_count
);
    localparam int                    c_AW        = $clog2(DEPTH);
    localparam logic [c_AW:0]         c_DEPTH_CNT = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]         c_ONE_CNT   = (c_AW+1)'(1);
    localparam logic [c_AW-1:0]       c_ONE_PTR   = c_AW'(1);
    localparam logic [CNT_W-1:0]      c_ONE_CTR   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      c_CYC_LAST  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [31:0]           c_EBREAK    = 32'h0010_0073;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       w_cause_nxt;

    logic [XLEN-1:0]  r_mem_pc   [DEPTH];
    logic [31:0]      r_mem_inst [DEPTH];
    logic             r_mem_we   [DEPTH];
    logic [4:0]       r_mem_addr [DEPTH];
    logic [XLEN-1:0]  r_mem_data [DEPTH];

    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;

    logic w_run;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_drop_oldest;

    assign w_run         = (r_state == ST_RUN);
    assign w_push        = w_run && trc.ret_valid;
    assign w_full        = (count == c_DEPTH_CNT);
    assign w_pop         = trc.pop && (count != '0);
    // A push into a full buffer without a matching pop evicts the oldest entry.
    assign w_drop_oldest = w_push && !w_pop && w_full;
    assign halt          = (r_state == ST_HALTED);

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = halt_cause;
        case (r_state)
            ST_RUN: begin
                if (trc.ret_valid && (trc.ret_inst == c_EBREAK)) begin
                    w_state_nxt = ST_HALTED;
                    w_cause_nxt = 2'd3;
                end else if (trc.ret_valid && bp_en && (trc.ret_pc == bp_pc)) begin
                    w_state_nxt = ST_HALTED;
                    w_cause_nxt = 2'd2;
                end else if ((MAX_CYCLES != 0) && (cycle_count == c_CYC_LAST)) begin
                    w_state_nxt = ST_HALTED;
                    w_cause_nxt = 2'd1;
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            halt_cause <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            halt_cause <= w_cause_nxt;
        end
    end

    // Trace storage carries no reset; validity is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= trc.ret_pc;
            r_mem_inst[r_wr_ptr] <= trc.ret_inst;
            r_mem_we[r_wr_ptr]   <= trc.ret_rd_we;
            r_mem_addr[r_wr_ptr] <= trc.ret_rd_addr;
            r_mem_data[r_wr_ptr] <= trc.ret_rd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            count           <= '0;
            overflow        <= 1'b0;
            cycle_count     <= '0;
            retire_count    <= '0;
            trc.pop_valid   <= 1'b0;
            trc.pop_pc      <= '0;
            trc.pop_inst    <= '0;
            trc.pop_rd_we   <= 1'b0;
            trc.pop_rd_addr <= '0;
            trc.pop_rd_data <= '0;
        end else begin
            if (w_run && (cycle_count != '1)) begin
                cycle_count <= cycle_count + c_ONE_CTR;
            end
            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + c_ONE_PTR;
                retire_count <= retire_count + c_ONE_CTR;
            end
            if (w_pop || w_drop_oldest) begin
                r_rd_ptr <= r_rd_ptr + c_ONE_PTR;
            end
            if (w_drop_oldest) begin
                overflow <= 1'b1;
            end
            if (w_push && !w_pop && !w_full) begin
                count <= count + c_ONE_CNT;
            end else if (w_pop && !w_push) begin
                count <= count - c_ONE_CNT;
            end

            trc.pop_valid <= w_pop;
            if (w_pop) begin
                trc.pop_pc      <= r_mem_pc[r_rd_ptr];
                trc.pop_inst    <= r_mem_inst[r_rd_ptr];
                trc.pop_rd_we   <= r_mem_we[r_rd_ptr];
                trc.pop_rd_addr <= r_mem_addr[r_rd_ptr];
                trc.pop_rd_data <= r_mem_data[r_rd_ptr];
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_retire_trace_monitor.sv
// ============================================================================
// Module      : tb_retire_trace_monitor
// Description : Self-checking bench for retire_trace_monitor against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_retire_trace_monitor;
    localparam int XLEN       = 32;
    localparam int DEPTH      = 16;
    localparam int MAX_CYCLES = 8000;
    localparam int CNT_W      = 32;
    localparam logic [31:0] c_EBREAK = 32'h0010_0073;
    localparam logic [31:0] c_NOP    = 32'h0000_0013;

    logic                 clk;
    logic                 rst;
    logic                 bp_en;
    logic [XLEN-1:0]      bp_pc;
    logic [$clog2(DEPTH):0] count;
    logic                 overflow;
    logic                 halt;
    logic [1:0]           halt_cause;
    logic [CNT_W-1:0]     cycle_count;
    logic [CNT_W-1:0]     retire_count;

    retire_trace_if #(.XLEN(XLEN)) trc ();

    retire_trace_monitor #(
        .XLEN(XLEN), .DEPTH(DEPTH), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .trc(trc), .bp_en(bp_en), .bp_pc(bp_pc),
        .count(count), .overflow(overflow), .halt(halt), .halt_cause(halt_cause),
        .cycle_count(cycle_count), .retire_count(retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    // Reference model: trace as a bounded queue, counters as plain integers.
    ent_t   m_q[$];
    ent_t   m_pop;
    bit     m_pop_valid;
    bit     m_ovf;
    bit     m_halt;
    int     m_cause;
    longint m_cyc;
    longint m_ret;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic model_reset();
        m_q.delete();
        m_pop       = '0;
        m_pop_valid = 0;
        m_ovf       = 0;
        m_halt      = 0;
        m_cause     = 0;
        m_cyc       = 0;
        m_ret       = 0;
    endtask

    task automatic model_step();
        ent_t e;
        bit   run;
        bit   push;
        bit   popd;
        run  = !m_halt;
        push = run && trc.ret_valid;
        popd = trc.pop && (m_q.size() > 0);
        e    = '{trc.ret_pc, trc.ret_inst, trc.ret_rd_we, trc.ret_rd_addr, trc.ret_rd_data};
        m_pop_valid = popd;
        if (popd) m_pop = m_q.pop_front();
        if (push) begin
            if (m_q.size() == DEPTH) begin
                void'(m_q.pop_front());
                m_ovf = 1;
            end
            m_q.push_back(e);
            m_ret++;
        end
        if (run) begin
            if (trc.ret_valid && trc.ret_inst == c_EBREAK) m_cause = 3;
            else if (trc.ret_valid && bp_en && trc.ret_pc == bp_pc) m_cause = 2;
            else if (MAX_CYCLES != 0 && m_cyc == MAX_CYCLES - 1) m_cause = 1;
            if (m_cause != 0) m_halt = 1;
            if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ret(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                           input bit we, input logic [4:0] addr, input logic [31:0] data);
        trc.ret_valid   = v;
        trc.ret_pc      = pc;
        trc.ret_inst    = inst;
        trc.ret_rd_we   = we;
        trc.ret_rd_addr = addr;
        trc.ret_rd_data = data;
    endtask

    task automatic do_reset();
        set_ret(0, '0, c_NOP, 0, '0, '0);
        trc.pop = 0;
        bp_en   = 0;
        bp_pc   = '0;
        rst     = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({trc.pop_valid, trc.pop_pc, trc.pop_inst, trc.pop_rd_we, trc.pop_rd_addr, trc.pop_rd_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_pop: got valid=%0b pc=%h data=%h, need all 0", trc.pop_valid, trc.pop_pc, trc.pop_rd_data);
        end
        n_tests++;
        if ({count, overflow, halt, halt_cause} !== '0) begin
            n_fail++;
            $display("FAIL reset_status: got count=%0d ovf=%0b halt=%0b cause=%0d, need 0", count, overflow, halt, halt_cause);
        end
        n_tests++;
        if (cycle_count !== '0 || retire_count !== '0) begin
            n_fail++;
            $display("FAIL reset_counters: got cyc=%0d ret=%0d, need 0", cycle_count, retire_count);
        end
    endtask

    task automatic test_basic_order();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_ret(1, 32'(i * 4), c_NOP, 1, 5'(i + 1), $urandom);
            model_step();
            n_tests++;
            if (count !== 5'(i + 1)) begin
                n_fail++;
                $display("FAIL basic_count_up: got %0d, need %0d", count, i + 1);
            end
        end
        set_ret(0, '0, c_NOP, 0, '0, '0);
        trc.pop = 1;
        for (int i = 0; i < 5; i++) begin
            model_step();
            n_tests++;
            if (trc.pop_valid !== 1'b1 || trc.pop_pc !== 32'(i * 4) || trc.pop_rd_data !== m_pop.data
                || trc.pop_rd_addr !== 5'(i + 1) || count !== 5'(4 - i)) begin
                n_fail++;
                $display("FAIL basic_pop%0d: got v=%0b pc=%h data=%h count=%0d, need v=1 pc=%h data=%h count=%0d",
                         i, trc.pop_valid, trc.pop_pc, trc.pop_rd_data, count, i * 4, m_pop.data, 4 - i);
            end
        end
        trc.pop = 0;
        n_tests++;
        if (retire_count !== 32'd5 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_totals: got ret=%0d ovf=%0b, need ret=5 ovf=0", retire_count, overflow);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_ret(1, 32'(i * 4), c_NOP, 0, '0, $urandom);
            model_step();
        end
        set_ret(0, '0, c_NOP, 0, '0, '0);
        n_tests++;
        if (count !== 5'd16 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_state: got count=%0d ovf=%0b, need count=16 ovf=1", count, overflow);
        end
        trc.pop = 1;
        for (int i = 0; i < 16; i++) begin
            model_step();
            n_tests++;
            if (trc.pop_valid !== 1'b1 || trc.pop_pc !== 32'((i + 4) * 4) || trc.pop_rd_data !== m_pop.data) begin
                n_fail++;
                $display("FAIL ovf_pop%0d: got v=%0b pc=%h data=%h, need v=1 pc=%h data=%h",
                         i, trc.pop_valid, trc.pop_pc, trc.pop_rd_data, (i + 4) * 4, m_pop.data);
            end
        end
        model_step();
        trc.pop = 0;
        n_tests++;
        if (trc.pop_valid !== 1'b0 || count !== '0) begin
            n_fail++;
            $display("FAIL ovf_pop_empty: got v=%0b count=%0d, need v=0 count=0", trc.pop_valid, count);
        end
    endtask

    task automatic test_push_pop_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_ret(1, 32'h100 + 32'(i * 4), c_NOP, 1, 5'(i), $urandom);
            model_step();
        end
        set_ret(1, 32'h200, c_NOP, 1, 5'd7, 32'hCAFE);
        trc.pop = 1;
        model_step();
        n_tests++;
        if (trc.pop_valid !== 1'b1 || trc.pop_pc !== 32'h100 || count !== 5'd16 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL pushpop_full: got v=%0b pc=%h count=%0d ovf=%0b, need v=1 pc=100 count=16 ovf=0",
                     trc.pop_valid, trc.pop_pc, count, overflow);
        end
        set_ret(0, '0, c_NOP, 0, '0, '0);
        model_step();
        trc.pop = 0;
        n_tests++;
        if (trc.pop_pc !== 32'h104 || count !== 5'd15) begin
            n_fail++;
            $display("FAIL pushpop_next: got pc=%h count=%0d, need pc=104 count=15", trc.pop_pc, count);
        end
    endtask

    task automatic test_random();
        logic [31:0] inst;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            inst = $urandom;
            if (inst == c_EBREAK) inst = inst ^ 32'h1;
            set_ret(($urandom_range(0, 9) < 6), $urandom & 32'hFFFF_FFFC, inst,
                    1'($urandom), 5'($urandom), $urandom);
            trc.pop = ($urandom_range(0, 9) < 4);
            model_step();
            n_tests++;
            if (trc.pop_valid !== m_pop_valid || count !== 5'(m_q.size()) || overflow !== m_ovf
                || retire_count !== 32'(m_ret) || cycle_count !== 32'(m_cyc) || halt !== m_halt
                || (m_pop_valid && ({trc.pop_pc, trc.pop_inst, trc.pop_rd_we, trc.pop_rd_addr, trc.pop_rd_data} !== m_pop))) begin
                n_fail++;
                $display("FAIL random_c%0d: got v=%0b pc=%h cnt=%0d ovf=%0b ret=%0d cyc=%0d, need v=%0b pc=%h cnt=%0d ovf=%0b ret=%0d cyc=%0d",
                         i, trc.pop_valid, trc.pop_pc, count, overflow, retire_count, cycle_count,
                         m_pop_valid, m_pop.pc, m_q.size(), m_ovf, m_ret, m_cyc);
            end
        end
        set_ret(0, '0, c_NOP, 0, '0, '0);
        trc.pop = 0;
    endtask

    task automatic test_breakpoint();
        logic [CNT_W-1:0] cyc_frozen;
        do_reset();
        bp_en = 1;
        bp_pc = 32'h24;
        for (int i = 0; i < 10; i++) begin
            set_ret(1, 32'(i * 4), c_NOP, 1, 5'(i), $urandom);
            model_step();
        end
        n_tests++;
        if (halt !== 1'b1 || halt_cause !== 2'd2 || 2'(m_cause) !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_halt: got halt=%0b cause=%0d, need halt=1 cause=2", halt, halt_cause);
        end
        cyc_frozen = cycle_count;
        set_ret(1, 32'h28, c_NOP, 1, 5'd3, 32'h55);
        model_step();
        set_ret(0, '0, c_NOP, 0, '0, '0);
        n_tests++;
        if (retire_count !== 32'd10 || count !== 5'd10 || cycle_count !== cyc_frozen) begin
            n_fail++;
            $display("FAIL bp_frozen: got ret=%0d count=%0d cyc=%0d, need ret=10 count=10 cyc=%0d",
                     retire_count, count, cycle_count, cyc_frozen);
        end
        trc.pop = 1;
        for (int i = 0; i < 10; i++) begin
            model_step();
        end
        trc.pop = 0;
        n_tests++;
        if (trc.pop_valid !== 1'b1 || trc.pop_pc !== 32'h24 || trc.pop_rd_data !== m_pop.data || count !== '0) begin
            n_fail++;
            $display("FAIL bp_last_entry: got v=%0b pc=%h count=%0d, need v=1 pc=24 count=0",
                     trc.pop_valid, trc.pop_pc, count);
        end
    endtask

    task automatic test_cycle_limit();
        do_reset();
        for (int i = 0; i < MAX_CYCLES - 1; i++) model_step();
        n_tests++;
        if (halt !== 1'b0 || cycle_count !== 32'(MAX_CYCLES - 1)) begin
            n_fail++;
            $display("FAIL limit_before: got halt=%0b cyc=%0d, need halt=0 cyc=%0d", halt, cycle_count, MAX_CYCLES - 1);
        end
        model_step();
        n_tests++;
        if (halt !== 1'b1 || cycle_count !== 32'd8000 || halt_cause !== 2'd1 || halt !== m_halt) begin
            n_fail++;
            $display("FAIL limit_hit: got halt=%0b cyc=%0d cause=%0d, need halt=1 cyc=8000 cause=1",
                     halt, cycle_count, halt_cause);
        end
        repeat (3) model_step();
        n_tests++;
        if (cycle_count !== 32'd8000 || halt !== 1'b1) begin
            n_fail++;
            $display("FAIL limit_frozen: got cyc=%0d halt=%0b, need cyc=8000 halt=1", cycle_count, halt);
        end
    endtask

    task automatic test_ebreak_async_reset();
        do_reset();
        bp_en = 1;
        bp_pc = 32'h40;
        set_ret(1, 32'h40, c_EBREAK, 0, '0, '0);
        model_step();
        set_ret(0, '0, c_NOP, 0, '0, '0);
        n_tests++;
        if (halt !== 1'b1 || halt_cause !== 2'd3 || 2'(m_cause) !== 2'd3) begin
            n_fail++;
            $display("FAIL ebreak_cause: got halt=%0b cause=%0d, need halt=1 cause=3", halt, halt_cause);
        end
        trc.pop = 1;
        model_step();
        n_tests++;
        if (trc.pop_valid !== 1'b1 || trc.pop_pc !== 32'h40 || trc.pop_inst !== c_EBREAK) begin
            n_fail++;
            $display("FAIL ebreak_pop: got v=%0b pc=%h inst=%h, need v=1 pc=40 inst=%h",
                     trc.pop_valid, trc.pop_pc, trc.pop_inst, c_EBREAK);
        end
        #1;
        rst = 1;
        #1;
        n_tests++;
        if ({trc.pop_valid, trc.pop_pc, trc.pop_inst, count, overflow, halt, halt_cause, cycle_count, retire_count} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%0b pc=%h cnt=%0d halt=%0b cause=%0d cyc=%0d ret=%0d, need all 0",
                     trc.pop_valid, trc.pop_pc, count, halt, halt_cause, cycle_count, retire_count);
        end
        #3;
        rst     = 0;
        trc.pop = 0;
        bp_en   = 0;
        model_reset();
        set_ret(1, 32'h80, c_NOP, 1, 5'd9, 32'h1234);
        model_step();
        set_ret(0, '0, c_NOP, 0, '0, '0);
        n_tests++;
        if (halt !== 1'b0 || count !== 5'(m_q.size()) || retire_count !== 32'(m_ret) || cycle_count !== 32'(m_cyc)) begin
            n_fail++;
            $display("FAIL post_reset_run: got halt=%0b cnt=%0d ret=%0d cyc=%0d, need halt=0 cnt=%0d ret=%0d cyc=%0d",
                     halt, count, retire_count, cycle_count, m_q.size(), m_ret, m_cyc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        test_reset();
        test_basic_order();
        test_overflow();
        test_push_pop_full();
        test_random();
        test_breakpoint();
        test_cycle_limit();
        test_ebreak_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
